// File: rtl/sram_defs.sv
// Shared definitions for the Ram1 async SRAM access sequencer:
// FSM state encodings, default bus widths and active-low strobe levels.
package sram_defs;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_SETUP = 3'd1,
        ST_W_PULSE = 3'd2,
        ST_W_HOLD  = 3'd3,
        ST_R_WAIT  = 3'd4,
        ST_R_DONE  = 3'd5
    } sram_state_t;

endpackage

// File: rtl/sram_access_seq.sv
// Sequences single-word read/write requests onto the Ram1 async SRAM,
// owning setup, WE pulse width, hold, read access wait and data capture.
module sram_access_seq
    import sram_defs::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int WE_CYCLES = 1,
    parameter int RD_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] Ram1Addr,
    inout  wire  [DATA_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN
);

    localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    sram_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;

    assign req_ready = (state == ST_IDLE) && !RST;
    assign busy      = !req_ready;
    assign Ram1Data  = drive_en ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            drive_en  <= 1'b0;
            Ram1Addr  <= '0;
            Ram1EN    <= STROBE_OFF;
            Ram1OE    <= STROBE_OFF;
            Ram1WE    <= STROBE_OFF;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        Ram1Addr <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt      <= '0;
                        Ram1EN   <= STROBE_ON;
                        if (req_we) begin
                            state    <= ST_W_SETUP;
                            drive_en <= 1'b1;
                        end else begin
                            state  <= ST_R_WAIT;
                            Ram1OE <= STROBE_ON;
                        end
                    end
                end
                ST_W_SETUP: begin
                    state  <= ST_W_PULSE;
                    Ram1WE <= STROBE_ON;
                end
                ST_W_PULSE: begin
                    if (cnt == WE_LAST) begin
                        state  <= ST_W_HOLD;
                        Ram1WE <= STROBE_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_W_HOLD: begin
                    // Data stays on the bus one cycle past the WE rising edge
                    state    <= ST_IDLE;
                    Ram1EN   <= STROBE_OFF;
                    drive_en <= 1'b0;
                end
                ST_R_WAIT: begin
                    if (cnt == RD_LAST) begin
                        state     <= ST_R_DONE;
                        Ram1OE    <= STROBE_OFF;
                        Ram1EN    <= STROBE_OFF;
                        rsp_rdata <= Ram1Data;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_R_DONE: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    drive_en  <= 1'b0;
                    Ram1EN    <= STROBE_OFF;
                    Ram1OE    <= STROBE_OFF;
                    Ram1WE    <= STROBE_OFF;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with a behavioural async SRAM
// attached to the shared Ram1 bus.
module tb_sram_access_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [17:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [17:0] Ram1Addr;
    wire  [15:0] Ram1Data;
    logic        Ram1OE;
    logic        Ram1WE;
    logic        Ram1EN;

    int checks = 0;
    int errors = 0;
    bit inv_on = 1'b0;

    logic [15:0] mem [0:63];

    sram_access_seq #(
        .ADDR_W(18), .DATA_W(16), .WE_CYCLES(1), .RD_CYCLES(2)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data),
        .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN)
    );

    always #5 CLK = ~CLK;

    // Async SRAM: drives on EN&OE with WE high, latches on WE rising edge
    assign Ram1Data = (Ram1EN === 1'b0 && Ram1OE === 1'b0 && Ram1WE === 1'b1)
                      ? mem[Ram1Addr[5:0]] : 16'hzzzz;

    always @(posedge Ram1WE)
        if (Ram1EN === 1'b0) mem[Ram1Addr[5:0]] <= Ram1Data;

    always @(negedge CLK) begin
        if (inv_on) begin
            checks++;
            assert (!(Ram1OE === 1'b0 && dut.drive_en === 1'b1)) else begin
                errors++;
                $error("FAIL inv_oe_drive: OE=%b drive_en=%b", Ram1OE, dut.drive_en);
            end
            checks++;
            assert (!(Ram1OE === 1'b0 && Ram1WE === 1'b0)) else begin
                errors++;
                $error("FAIL inv_oe_we: OE=%b WE=%b", Ram1OE, Ram1WE);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobes(input string tag, input logic en, input logic oe, input logic we);
        check({tag, "_en"}, {31'd0, Ram1EN}, {31'd0, en});
        check({tag, "_oe"}, {31'd0, Ram1OE}, {31'd0, oe});
        check({tag, "_we"}, {31'd0, Ram1WE}, {31'd0, we});
    endtask

    initial begin
        int n;
        int pulses;
        logic [15:0] got;

        for (int i = 0; i < 64; i++) mem[i] = 16'h0;

        // Reset
        step();
        step();
        inv_on = 1'b1;
        strobes("rst", 1'b1, 1'b1, 1'b1);
        check("rst_bus_z", {31'd0, Ram1Data === 16'hzzzz}, 32'd1);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        check("rst_addr", {14'd0, Ram1Addr}, 32'd0);
        check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        RST = 1'b0;
        #1;
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single write
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 18'h00010; req_wdata = 16'hA5A5;
        step();
        req_valid = 1'b0; req_addr = 18'h3FFFF; req_wdata = 16'hFFFF;
        strobes("wsetup", 1'b0, 1'b1, 1'b1);
        check("wsetup_bus", {16'd0, Ram1Data}, 32'h0000A5A5);
        check("wsetup_addr", {14'd0, Ram1Addr}, 32'h00010);
        check("wsetup_ready", {31'd0, req_ready}, 32'd0);
        step();
        strobes("wpulse", 1'b0, 1'b1, 1'b0);
        check("wpulse_bus", {16'd0, Ram1Data}, 32'h0000A5A5);
        step();
        strobes("whold", 1'b0, 1'b1, 1'b1);
        check("whold_bus", {16'd0, Ram1Data}, 32'h0000A5A5);
        check("whold_ready", {31'd0, req_ready}, 32'd0);
        step();
        strobes("widle", 1'b1, 1'b1, 1'b1);
        check("widle_bus_z", {31'd0, Ram1Data === 16'hzzzz}, 32'd1);
        check("widle_ready", {31'd0, req_ready}, 32'd1);
        check("widle_addr", {14'd0, Ram1Addr}, 32'h00010);
        check("wmem", {16'd0, mem[16]}, 32'h0000A5A5);

        // Single read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00010;
        step();
        req_valid = 1'b0;
        strobes("rwait1", 1'b0, 1'b0, 1'b1);
        check("rwait1_drv", {31'd0, dut.drive_en}, 32'd0);
        check("rwait1_rspv", {31'd0, rsp_valid}, 32'd0);
        step();
        strobes("rwait2", 1'b0, 1'b0, 1'b1);
        check("rwait2_rspv", {31'd0, rsp_valid}, 32'd0);
        step();
        strobes("rdone", 1'b1, 1'b1, 1'b1);
        check("rdone_rspv", {31'd0, rsp_valid}, 32'd1);
        check("rdone_rdata", {16'd0, rsp_rdata}, 32'h0000A5A5);
        check("rdone_ready", {31'd0, req_ready}, 32'd0);
        step();
        check("ridle_rspv", {31'd0, rsp_valid}, 32'd0);
        check("ridle_rdata", {16'd0, rsp_rdata}, 32'h0000A5A5);
        check("ridle_ready", {31'd0, req_ready}, 32'd1);

        // Back-to-back writes, valid held high throughout
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_we = 1'b1;
            req_addr = 18'h20 + 18'(i); req_wdata = 16'(i);
            step();
            if (i == 9) req_valid = 1'b0;
            n = 0;
            while (!req_ready && n < 10) begin
                step();
                n++;
            end
            check($sformatf("b2b_w%0d_cycles", i), n, 32'd3);
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("b2b_mem%0d", i), {16'd0, mem[32 + i]}, i);

        // Back-to-back reads
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_we = 1'b0;
            req_addr = 18'h20 + 18'(i);
            step();
            if (i == 9) req_valid = 1'b0;
            n = 0;
            pulses = 0;
            got = 16'hDEAD;
            while (!req_ready && n < 10) begin
                step();
                n++;
                if (rsp_valid) begin
                    pulses++;
                    got = rsp_rdata;
                end
            end
            check($sformatf("b2b_r%0d_cycles", i), n, 32'd3);
            check($sformatf("b2b_r%0d_pulses", i), pulses, 32'd1);
            check($sformatf("b2b_r%0d_data", i), {16'd0, got}, i);
        end

        // Reset during the WE pulse
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 18'h0003F; req_wdata = 16'h1234;
        step();
        req_valid = 1'b0;
        step();
        check("mid_we_low", {31'd0, Ram1WE}, 32'd0);
        RST = 1'b1;
        step();
        strobes("midrst", 1'b1, 1'b1, 1'b1);
        check("midrst_bus_z", {31'd0, Ram1Data === 16'hzzzz}, 32'd1);
        check("midrst_rspv", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        RST = 1'b0;
        step();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_rspv", {31'd0, rsp_valid}, 32'd0);
        step();

        inv_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
